// File: rtl/serial_adder.sv
// Multi-cycle adder/subtractor: a chain of full-adder cells processes
// BITS_PER_CYCLE bits per clock, with the carry held in a register between slices.

module serial_adder_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_adder #(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Ci,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Co,
  output logic             ovf
);
  localparam int BPC   = BITS_PER_CYCLE;
  localparam int STEPS = WIDTH / BPC;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  if (WIDTH < 2 || BPC < 1 || BPC > WIDTH || (WIDTH % BPC) != 0) begin : g_bad_param
    $error("serial_adder: BITS_PER_CYCLE must evenly divide WIDTH (WIDTH >= 2)");
  end

  typedef enum logic {IDLE, RUN} state_t;
  state_t state;

  logic [WIDTH-1:0] a_sh, b_sh, res_sh, res_next;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [BPC:0]     c;
  logic [BPC-1:0]   sum;
  logic             last;

  assign c[0] = carry;

  for (genvar i = 0; i < BPC; i++) begin : g_fa
    serial_adder_fa u_fa (
      .a  (a_sh[i]),
      .b  (b_sh[i]),
      .ci (c[i]),
      .s  (sum[i]),
      .co (c[i+1])
    );
  end

  // Result fills from the top; after STEPS shifts the first slice sits at bit 0.
  assign res_next = (res_sh >> BPC) | (WIDTH'(sum) << (WIDTH - BPC));
  assign last     = (cnt == CW'(STEPS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      S      <= '0;
      Co     <= 1'b0;
      ovf    <= 1'b0;
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state <= RUN;
          busy  <= 1'b1;
          a_sh  <= A;
          b_sh  <= B ^ {WIDTH{sub}};
          carry <= Ci ^ sub;
          cnt   <= '0;
        end
        RUN: begin
          a_sh   <= a_sh >> BPC;
          b_sh   <= b_sh >> BPC;
          res_sh <= res_next;
          carry  <= c[BPC];
          cnt    <= cnt + 1'b1;
          if (last) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
            S     <= res_next;
            Co    <= c[BPC];
            ovf   <= c[BPC-1] ^ c[BPC];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
// Directed and random checks of serial_adder for WIDTH=8 and WIDTH=16 at every legal BITS_PER_CYCLE.

module tb_serial_adder;
  localparam int NI = 9;  // 0..3: W8 BPC 1,2,4,8 ; 4..8: W16 BPC 1,2,4,8,16

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        sub = 1'b0;
  logic        Ci = 1'b0;
  logic [15:0] A16 = '0;
  logic [15:0] B16 = '0;

  logic [NI-1:0] busy_v, done_v, co_v, ovf_v;
  logic [15:0]   s_v [NI];

  int total = 0;
  int passes = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g8
    logic [7:0] s;
    serial_adder #(.WIDTH(8), .BITS_PER_CYCLE(1 << g)) u (
      .clk(clk), .rst_n(rst_n), .start(start), .sub(sub),
      .A(A16[7:0]), .B(B16[7:0]), .Ci(Ci),
      .busy(busy_v[g]), .done(done_v[g]), .S(s), .Co(co_v[g]), .ovf(ovf_v[g])
    );
    assign s_v[g] = {8'h00, s};
  end

  for (genvar g = 0; g < 5; g++) begin : g16
    serial_adder #(.WIDTH(16), .BITS_PER_CYCLE(1 << g)) u (
      .clk(clk), .rst_n(rst_n), .start(start), .sub(sub),
      .A(A16), .B(B16), .Ci(Ci),
      .busy(busy_v[4+g]), .done(done_v[4+g]), .S(s_v[4+g]), .Co(co_v[4+g]), .ovf(ovf_v[4+g])
    );
  end

  function automatic int wid(input int i);
    return (i < 4) ? 8 : 16;
  endfunction

  function automatic int steps(input int i);
    return (i < 4) ? (8 >> i) : (16 >> (i - 4));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Reference: plain integer add/subtract, signed overflow from operand/result signs.
  task automatic model(input int w, input logic [15:0] a, input logic [15:0] b,
                       input logic ci, input logic sb,
                       output logic [15:0] s, output logic co, output logic ov);
    logic [16:0] mask, am, bm, full;
    mask = (17'd1 << w) - 17'd1;
    am = {1'b0, a} & mask;
    bm = {1'b0, b} & mask;
    if (!sb) begin
      full = am + bm + {16'd0, ci};
      co   = full[w];
      ov   = (am[w-1] == bm[w-1]) && (full[w-1] != am[w-1]);
    end else begin
      full = (am - bm - {16'd0, ci}) & mask;
      co   = (am >= bm + {16'd0, ci});
      ov   = (am[w-1] != bm[w-1]) && (full[w-1] != am[w-1]);
    end
    s = full[15:0] & mask[15:0];
  endtask

  // Launch one op on all instances and check latency, busy length, single done, results.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic ci,
                        input logic sb, input string tag);
    int lat[NI], bcnt[NI], dcnt[NI];
    logic [15:0] rs[NI];
    logic rc[NI], ro[NI];
    logic [15:0] es;
    logic ec, eo;
    for (int i = 0; i < NI; i++) begin
      lat[i] = 0; bcnt[i] = 0; dcnt[i] = 0; rs[i] = '0; rc[i] = 1'b0; ro[i] = 1'b0;
    end
    A16 = a; B16 = b; Ci = ci; sub = sb; start = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (c == 2) begin A16 = ~a; B16 = ~b; Ci = ~ci; sub = ~sb; end
      for (int i = 0; i < NI; i++) begin
        if (busy_v[i]) bcnt[i]++;
        if (done_v[i]) begin
          dcnt[i]++;
          if (lat[i] == 0) begin lat[i] = c; rs[i] = s_v[i]; rc[i] = co_v[i]; ro[i] = ovf_v[i]; end
        end
      end
    end
    for (int i = 0; i < NI; i++) begin
      model(wid(i), a, b, ci, sb, es, ec, eo);
      chk($sformatf("%s.i%0d.lat", tag, i), lat[i], steps(i) + 1);
      chk($sformatf("%s.i%0d.busy", tag, i), bcnt[i], steps(i));
      chk($sformatf("%s.i%0d.ndone", tag, i), dcnt[i], 1);
      chk($sformatf("%s.i%0d.S", tag, i), {16'd0, rs[i]}, {16'd0, es});
      chk($sformatf("%s.i%0d.Co", tag, i), {31'd0, rc[i]}, {31'd0, ec});
      chk($sformatf("%s.i%0d.ovf", tag, i), {31'd0, ro[i]}, {31'd0, eo});
      chk($sformatf("%s.i%0d.hold", tag, i), {16'd0, s_v[i]}, {16'd0, es});
    end
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) @(negedge clk);
  endtask

  initial begin
    int lat1, lat2, nd;
    logic [15:0] s2;

    // reset state
    idle(3);
    chk("rst.busy", {23'd0, busy_v}, 32'd0);
    chk("rst.done", {23'd0, done_v}, 32'd0);
    chk("rst.co", {23'd0, co_v}, 32'd0);
    chk("rst.ovf", {23'd0, ovf_v}, 32'd0);
    chk("rst.S0", {16'd0, s_v[0]}, 32'd0);
    chk("rst.S8", {16'd0, s_v[8]}, 32'd0);
    rst_n = 1'b1;
    idle(2);

    // directed vectors (8-bit expectations hand-computed; all widths modelled)
    run_op(16'h005A, 16'h0033, 1'b0, 1'b0, "add5a33");
    chk("t1.S", {16'd0, s_v[0]}, 32'h8D);
    chk("t1.ovf", {31'd0, ovf_v[0]}, 32'd1);
    run_op(16'h00FF, 16'h0001, 1'b0, 1'b0, "addff01");
    chk("t2a.S", {16'd0, s_v[0]}, 32'h00);
    chk("t2a.Co", {31'd0, co_v[0]}, 32'd1);
    run_op(16'h007F, 16'h0000, 1'b1, 1'b0, "add7f_ci");
    chk("t2b.S", {16'd0, s_v[0]}, 32'h80);
    chk("t2b.ovf", {31'd0, ovf_v[0]}, 32'd1);
    run_op(16'h0010, 16'h0001, 1'b0, 1'b1, "sub10_01");
    chk("t3a.S", {16'd0, s_v[0]}, 32'h0F);
    chk("t3a.Co", {31'd0, co_v[0]}, 32'd1);
    run_op(16'h0000, 16'h0001, 1'b0, 1'b1, "sub00_01");
    chk("t3b.S", {16'd0, s_v[0]}, 32'hFF);
    chk("t3b.Co", {31'd0, co_v[0]}, 32'd0);
    run_op(16'h0005, 16'h0005, 1'b1, 1'b1, "sub05_05b");
    chk("t3c.S", {16'd0, s_v[0]}, 32'hFF);
    chk("t3c.Co", {31'd0, co_v[0]}, 32'd0);
    run_op(16'h0099, 16'h0067, 1'b0, 1'b0, "add9967");
    chk("t4.S_bpc4", {16'd0, s_v[2]}, 32'h00);
    chk("t4.Co_bpc4", {31'd0, co_v[2]}, 32'd1);
    run_op(16'hFFFF, 16'h0001, 1'b1, 1'b0, "add16wrap");
    run_op(16'h8000, 16'h0001, 1'b0, 1'b1, "sub16ovf");

    // start while busy is ignored (instance 0: W8, BPC1)
    A16 = 16'h0012; B16 = 16'h0034; Ci = 1'b0; sub = 1'b0; start = 1'b1;
    lat1 = 0; nd = 0; s2 = '0;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (c == 3) begin A16 = 16'h0077; B16 = 16'h0011; start = 1'b1; end
      if (c == 4) start = 1'b0;
      if (done_v[0]) begin nd++; if (lat1 == 0) begin lat1 = c; s2 = s_v[0]; end end
    end
    chk("ign.lat", lat1, 9);
    chk("ign.ndone", nd, 1);
    chk("ign.S", {16'd0, s2}, 32'h46);
    idle(20);

    // back-to-back: start held high across done
    A16 = 16'h0001; B16 = 16'h0002; Ci = 1'b0; sub = 1'b0; start = 1'b1;
    lat1 = 0; lat2 = 0; nd = 0; s2 = '0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (done_v[0]) begin
        nd++;
        if (lat1 == 0) lat1 = c;
        else if (lat2 == 0) begin lat2 = c; s2 = s_v[0]; end
      end
      if (c == 9) begin A16 = 16'h0010; B16 = 16'h0020; end
      if (c == 10) begin start = 1'b0; chk("b2b.busy", {31'd0, busy_v[0]}, 32'd1); end
      if (c == 12) chk("b2b.hold", {16'd0, s_v[0]}, 32'h03);
    end
    chk("b2b.lat1", lat1, 9);
    chk("b2b.lat2", lat2, 18);
    chk("b2b.ndone", nd, 2);
    chk("b2b.S2", {16'd0, s2}, 32'h30);
    idle(20);

    // reset mid-operation
    A16 = 16'h005A; B16 = 16'h0033; Ci = 1'b0; sub = 1'b0; start = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
    end
    #1 rst_n = 1'b0;
    #1;
    chk("mrst.busy", {31'd0, busy_v[0]}, 32'd0);
    chk("mrst.done", {31'd0, done_v[0]}, 32'd0);
    chk("mrst.S", {16'd0, s_v[0]}, 32'd0);
    chk("mrst.Co", {31'd0, co_v[0]}, 32'd0);
    chk("mrst.ovf", {31'd0, ovf_v[0]}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done_v != '0) nd++;
    end
    chk("mrst.nodone", nd, 0);
    run_op(16'h005A, 16'h0033, 1'b0, 1'b0, "postrst");

    // random operands, all widths and slice sizes
    for (int r = 0; r < 12; r++) begin
      run_op(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), $sformatf("rnd%0d", r));
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
